// File: rtl/vga_rect_engine.sv
// Queued rectangle rasteriser driving the 160x120 VGA adapter's plot/x/y/colour inputs.
// Optional feature macro RECT_OUTLINE_EN: outline-only rendering when cmd_outline is set.
module vga_rect_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int DEPTH    = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [X_W-1:0]     cmd_w,
    input  logic [Y_W-1:0]     cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               cmd_outline,
    output logic               plot,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done
);
    localparam int PTR_W = $clog2(DEPTH);
`ifdef RECT_OUTLINE_EN
    localparam int ENT_W = 2*X_W + 2*Y_W + COLOR_W + 1;
`else
    localparam int ENT_W = 2*X_W + 2*Y_W + COLOR_W;
`endif
    localparam logic [PTR_W:0] FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
    localparam logic [X_W:0]   SW      = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   SH      = (Y_W+1)'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
    state_t state;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   wdata;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               push, pop;

    logic [X_W-1:0]     head_x, head_w, wx, ww, i, ci;
    logic [Y_W-1:0]     head_y, head_h, wy, wh, j, cj;
    logic [COLOR_W-1:0] head_c, wc;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;
    logic               fin, emit, last_i, last_j, on_screen, suppress;

`ifdef RECT_OUTLINE_EN
    logic head_o, wo;
    assign wdata = {cmd_outline, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
    assign {head_o, head_x, head_y, head_w, head_h, head_c} = mem[rd_ptr];
    assign suppress = wo && (ci != '0) && !last_i && (cj != '0) && !last_j;
`else
    logic unused_outline;
    assign unused_outline = cmd_outline;
    assign wdata = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
    assign {head_x, head_y, head_w, head_h, head_c} = mem[rd_ptr];
    assign suppress = 1'b0;
`endif

    assign cmd_ready = (count != FULL);
    assign busy      = (count != '0) || (state != IDLE);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);

    // The LOAD cycle already emits pixel (0,0), so the counters hold the next pixel to emit.
    assign ci        = (state == LOAD) ? '0 : i;
    assign cj        = (state == LOAD) ? '0 : j;
    assign sum_x     = {1'b0, wx} + {1'b0, ci};
    assign sum_y     = {1'b0, wy} + {1'b0, cj};
    assign on_screen = (sum_x < SW) && (sum_y < SH);
    assign last_i    = (ci == ww - X_W'(1));
    assign last_j    = (cj == wh - Y_W'(1));
    assign emit      = ((state == LOAD) && (ww != '0) && (wh != '0)) ||
                       ((state == DRAW) && !fin);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
        if (pop) begin
            wx <= head_x;
            wy <= head_y;
            ww <= head_w;
            wh <= head_h;
            wc <= head_c;
`ifdef RECT_OUTLINE_EN
            wo <= head_o;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            color  <= '0;
            done   <= 1'b0;
            fin    <= 1'b0;
            i      <= '0;
            j      <= '0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;

            case (state)
                IDLE: if (pop) state <= LOAD;
                LOAD: begin
                    if ((ww == '0) || (wh == '0)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (fin) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Clipped or suppressed pixels still advance the scan and update x/y.
            if (emit) begin
                plot  <= on_screen && !suppress;
                x     <= sum_x[X_W-1:0];
                y     <= sum_y[Y_W-1:0];
                color <= wc;
                fin   <= last_i && last_j;
                if (last_i) begin
                    i <= '0;
                    j <= cj + Y_W'(1);
                end else begin
                    i <= ci + X_W'(1);
                    j <= cj;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_rect_engine.sv
// Bench for vga_rect_engine: queue-level behavioural model compared every cycle, plus literal scenario checks.
module tb_vga_rect_engine;
    localparam int DEPTH = 4;
`ifdef RECT_OUTLINE_EN
    localparam int OUTLINE_PIX = 10;
`else
    localparam int OUTLINE_PIX = 12;
`endif

    logic       clk = 1'b0;
    logic       resetn, cmd_valid, cmd_ready, cmd_outline;
    logic [7:0] cmd_x, cmd_w, x;
    logic [6:0] cmd_y, cmd_h, y;
    logic [2:0] cmd_color, color;
    logic       plot, busy, done;

    always #5 clk = ~clk;

    vga_rect_engine dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .cmd_outline(cmd_outline),
        .plot(plot), .x(x), .y(y), .color(color), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a command queue plus the cycle count since the current job was popped.
    typedef struct { int x, y, w, h, c, o; } cmd_t;
    cmd_t q[$];
    cmd_t cur;
    bit   active = 0;
    int   k = 0;
    bit   model_ok = 0;
    bit   e_plot = 0, e_done = 0;
    int   e_x = 0, e_y = 0, e_c = 0;
    int   plot_cnt = 0, done_cnt = 0, ready_low_cnt = 0;

    always @(posedge clk) begin
        int  n, ii, jj, px, py;
        bit  do_pop, do_push, inter;
        if (resetn) begin
            q.delete();
            active = 0;
            e_plot = 0; e_done = 0;
            e_x = 0; e_y = 0; e_c = 0;
            model_ok = 1;
        end else begin
            do_pop  = !active && (q.size() > 0);
            do_push = cmd_valid && (q.size() < DEPTH);
            e_plot = 0;
            e_done = 0;
            if (active) begin
                k++;
                n = cur.w * cur.h;
                if (k <= n) begin
                    ii = (k - 1) % cur.w;
                    jj = (k - 1) / cur.w;
                    px = cur.x + ii;
                    py = cur.y + jj;
`ifdef RECT_OUTLINE_EN
                    inter = (cur.o != 0) && ii > 0 && ii < cur.w - 1 && jj > 0 && jj < cur.h - 1;
`else
                    inter = 0;
`endif
                    e_plot = (px < 160) && (py < 120) && !inter;
                    e_x = px % 256;
                    e_y = py % 128;
                    e_c = cur.c;
                end else if (k == n + 1) begin
                    e_done = 1;
                end else begin
                    active = 0;
                end
            end
            if (do_pop) begin
                cur = q.pop_front();
                active = 1;
                k = 0;
            end
            if (do_push)
                q.push_back('{int'(cmd_x), int'(cmd_y), int'(cmd_w), int'(cmd_h),
                              int'(cmd_color), int'(cmd_outline)});
        end
    end

    always @(posedge clk) begin
        if (plot) plot_cnt++;
        if (done) done_cnt++;
        if (!cmd_ready) ready_low_cnt++;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("plot", int'(plot), int'(e_plot));
            chk("done", int'(done), int'(e_done));
            chk("busy", int'(busy), int'((q.size() > 0) || active));
            chk("cmd_ready", int'(cmd_ready), int'(q.size() < DEPTH));
            chk("x", int'(x), e_x);
            chk("y", int'(y), e_y);
            chk("color", int'(color), e_c);
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Offers one command from a negedge; returns at the negedge after the accepting edge.
    task automatic send(int cx, int cy, int cw, int ch, int cc, int co);
        int guard = 0;
        cmd_x = 8'(cx); cmd_y = 7'(cy); cmd_w = 8'(cw); cmd_h = 7'(ch);
        cmd_color = 3'(cc); cmd_outline = 1'(co);
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) chk("send_timeout", guard, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) chk("idle_timeout", guard, 0);
        step(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: got timeout expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0, r0;
        resetn = 1'b1; cmd_valid = 1'b0; cmd_outline = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        step(2);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_color", int'(color), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        resetn = 1'b0;
        step(1);

        // 3x2 rectangle at (10,20)
        p0 = plot_cnt;
        send(10, 20, 3, 2, 4, 0);
        step(2);
        chk("r1_first_plot", int'(plot), 1);
        chk("r1_first_x", int'(x), 10);
        chk("r1_first_y", int'(y), 20);
        chk("r1_first_c", int'(color), 4);
        step(5);
        chk("r1_last_x", int'(x), 12);
        chk("r1_last_y", int'(y), 21);
        step(1);
        chk("r1_done", int'(done), 1);
        chk("r1_done_plot", int'(plot), 0);
        step(1);
        chk("r1_busy_fall", int'(busy), 0);
        chk("r1_plots", plot_cnt - p0, 6);

        // Clipping at the bottom-right corner
        p0 = plot_cnt;
        send(158, 119, 4, 2, 7, 0);
        step(9);
        chk("clip_no_done_yet", int'(done), 0);
        step(1);
        chk("clip_done", int'(done), 1);
        chk("clip_plots", plot_cnt - p0, 2);
        wait_idle();

        // Zero-area command
        p0 = plot_cnt;
        send(5, 5, 0, 7, 1, 0);
        step(2);
        chk("zero_done", int'(done), 1);
        chk("zero_plots", plot_cnt - p0, 0);
        wait_idle();

        // Outline request
        p0 = plot_cnt;
        send(0, 0, 4, 3, 2, 1);
        wait_idle();
        chk("outline_plots", plot_cnt - p0, OUTLINE_PIX);

        // Queue fill with six 1x1 commands
        d0 = done_cnt;
        r0 = ready_low_cnt;
        for (int c = 0; c < 6; c++) send(c * 10, 50, 1, 1, c, 0);
        wait_idle();
        chk("fill_ready_dropped", int'(ready_low_cnt > r0), 1);
        chk("fill_done_pulses", done_cnt - d0, 6);

        // Reset mid-draw with two commands queued; a command offered during reset is dropped
        send(0, 0, 10, 10, 5, 0);
        send(20, 20, 2, 2, 1, 0);
        send(30, 30, 2, 2, 1, 0);
        step(5);
        resetn = 1'b1;
        cmd_valid = 1'b1;
        step(0);
        resetn = 1'b0;
        cmd_valid = 1'b0;
        chk("mid_rst_plot", int'(plot), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_done", int'(done), 0);
        d0 = done_cnt;
        step(20);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_still_idle", int'(busy), 0);

        // Randomized traffic with occasional resets
        for (int r = 0; r < 2500; r++) begin
            cmd_valid   = ($urandom_range(0, 3) == 0);
            cmd_x       = 8'($urandom_range(0, 1) ? $urandom_range(150, 255) : $urandom_range(0, 160));
            cmd_y       = 7'($urandom_range(0, 1) ? $urandom_range(110, 127) : $urandom_range(0, 120));
            cmd_w       = 8'($urandom_range(0, 5));
            cmd_h       = 7'($urandom_range(0, 4));
            cmd_color   = 3'($urandom_range(0, 7));
            cmd_outline = 1'($urandom_range(0, 1));
            resetn      = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        resetn = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
